// File: rtl/incr_sched.sv
// Round-robin scheduler sharing one CHUNK-bit incrementer among NREQ requesters.
// Each operand is incremented by one, CHUNK bits per cycle, carry rippled across cycles.
module incr_sched #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 70,
    parameter  int CHUNK = 16,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_carry
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int LAST_W = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic [PW-1:0]    r_op_pad;
    logic [PW-1:0]    r_res_pad;

    logic [NREQ-1:0]  w_rot;
    logic [IDW-1:0]   w_off;
    logic             w_any;
    logic [IDW:0]     w_gsum;
    logic [IDW-1:0]   w_grant;
    logic [WIDTH-1:0] w_ops [NREQ];
    logic [WIDTH-1:0] w_sel_op;
    logic [CHUNK:0]   w_sum;
    logic             w_last;
    logic             w_cout;
    logic [PW-1:0]    w_res_next;
    logic [IDW-1:0]   w_rr_next;

    // Rotate requests so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    assign w_rot = NREQ'({req_valid, req_valid} >> r_rr_ptr);

    always_comb begin
        w_off = '0;
        w_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDW'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_gsum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_grant = (w_gsum >= (IDW+1)'(NREQ)) ? IDW'(w_gsum - (IDW+1)'(NREQ)) : IDW'(w_gsum);

    always_comb begin
        req_ready = '0;
        if (!reset && r_state == S_IDLE && w_any) begin
            req_ready = NREQ'(1) << w_grant;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
        assign w_ops[gi] = req_data[gi*WIDTH +: WIDTH];
    end
    assign w_sel_op = w_ops[w_grant];

    // Operand is consumed from the bottom; result chunks enter at the top.
    assign w_sum  = {1'b0, r_op_pad[CHUNK-1:0]} + (CHUNK+1)'(r_carry);
    assign w_last = (r_k == KW'(NCHUNK - 1));
    assign w_cout = w_last ? w_sum[LAST_W] : w_sum[CHUNK];

    if (NCHUNK > 1) begin : g_multi
        logic w_pad_unused;
        assign w_res_next   = {w_sum[CHUNK-1:0], r_res_pad[PW-1:CHUNK]};
        assign w_pad_unused = ^r_res_pad[CHUNK-1:0];
    end else begin : g_single
        logic w_pad_unused;
        assign w_res_next   = w_sum[CHUNK-1:0];
        assign w_pad_unused = ^r_res_pad;
    end

    if (PW > WIDTH) begin : g_trim
        logic w_top_unused;
        assign w_top_unused = ^w_res_next[PW-1:WIDTH];
    end

    assign w_rr_next = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_k       <= '0;
            r_carry   <= 1'b0;
            r_op_pad  <= '0;
            r_res_pad <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op_pad <= PW'(w_sel_op);
                        r_id     <= w_grant;
                        r_k      <= '0;
                        r_carry  <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_op_pad  <= r_op_pad >> CHUNK;
                    r_res_pad <= w_res_next;
                    r_carry   <= w_cout;
                    r_k       <= r_k + 1'b1;
                    if (w_last) begin
                        r_state   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= w_res_next[WIDTH-1:0];
                        rsp_id    <= r_id;
                        rsp_carry <= w_cout;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_rr_ptr  <= w_rr_next;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_incr_sched.sv
// Scoreboard bench for incr_sched: stimulus pushes expected results, a monitor pops
// and compares on every response handshake.
module tb_incr_sched;
    localparam int NREQ   = 4;
    localparam int WIDTH  = 70;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = 5;

    typedef struct packed {
        logic [1:0]       id;
        logic [WIDTH-1:0] data;
        logic             carry;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [WIDTH-1:0]      rsp_data;
    logic [1:0]            rsp_id;
    logic                  rsp_carry;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    logic [WIDTH-1:0] rr_in  [4];
    logic [WIDTH-1:0] rr_exp [4];
    logic             rr_cy  [4];
    int               rr_seq [5];

    incr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_carry (rsp_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [WIDTH-1:0] ed, input logic ec);
        exp_t e;
        e.id    = 2'(idx);
        e.data  = ed;
        e.carry = ec;
        sb_q.push_back(e);
        $display("req accepted id=%0d expect data=%0h carry=%0d", idx, ed, ec);
    endtask

    // Single requester: wait for grant, check one-hot, then measure latency to rsp_valid.
    task automatic issue(input int idx, input logic [WIDTH-1:0] d,
                         input logic [WIDTH-1:0] ed, input logic ec);
        int n;
        int lat;
        req_data[idx*WIDTH +: WIDTH] = d;
        req_valid[idx] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 50);
        chk("grant", req_ready, 4'b0001 << idx);
        push_exp(idx, ed, ec);
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (rsp_valid) break;
            @(posedge clk);
            lat++;
        end
        chk("latency", lat, NCHUNK);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got id=%0d data=%0h, none expected", rsp_id, rsp_data);
                end else begin
                    e = sb_q.pop_front();
                    $display("rsp id=%0d data=%0h carry=%0d", rsp_id, rsp_data, rsp_carry);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_carry", rsp_carry, e.carry);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int g;
        rr_in[0] = 70'h5;                          rr_exp[0] = 70'h6;                          rr_cy[0] = 1'b0;
        rr_in[1] = 70'hFFFF;                       rr_exp[1] = 70'h1_0000;                     rr_cy[1] = 1'b0;
        rr_in[2] = 70'h3F_FFFF_FFFF_FFFF_FFFF;     rr_exp[2] = 70'h0;                          rr_cy[2] = 1'b1;
        rr_in[3] = 70'h12_3456_789A_BCDE_FFFF;     rr_exp[3] = 70'h12_3456_789A_BCDF_0000;     rr_cy[3] = 1'b0;
        rr_seq[0] = 0; rr_seq[1] = 1; rr_seq[2] = 2; rr_seq[3] = 3; rr_seq[4] = 0;

        // Reset state, with requests present
        reset = 1'b1;
        req_valid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_carry", rsp_carry, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = '0;

        issue(0, 70'h0, 70'h1, 1'b0);
        drain();
        issue(1, 70'h0_0000_0000_0000_FFFF, 70'h0_0000_0000_0001_0000, 1'b0);
        drain();
        issue(2, 70'h3F_FFFF_FFFF_FFFF_FFFF, 70'h0, 1'b1);
        drain();

        // Backpressure: result held, no new accept while stalled
        rsp_ready = 1'b0;
        issue(1, 70'h7FFF, 70'h8000, 1'b0);
        req_data[0 +: WIDTH] = 70'h9;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 70'h8000);
            chk("bp_rsp_id", rsp_id, 1);
            chk("bp_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Reset while computing chunk 2; the operation must vanish
        req_data[3*WIDTH +: WIDTH] = 70'h77;
        req_valid[3] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 50);
        chk("grant_pre_reset", req_ready, 4'b1000);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i*WIDTH +: WIDTH] = rr_in[i];
        req_valid = '1;
        @(negedge clk);
        chk("midreset_req_ready", req_ready, 0);
        chk("midreset_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round-robin with all requesters continuously valid
        g = 0;
        n = 0;
        while (g < 5 && n < 300) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) begin
                chk("rr_grant", req_ready, 4'b0001 << rr_seq[g]);
                push_exp(rr_seq[g], rr_exp[rr_seq[g]], rr_cy[rr_seq[g]]);
                g++;
            end
        end
        chk("rr_grant_count", g, 5);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
